// File: rtl/lcd_pkg.sv
// Shared LCD definitions: function codes, arbiter state encoding and a one-hot helper.
package lcd_pkg;

    localparam logic [3:0] FUNC_INIT      = 4'd0;
    localparam logic [3:0] FUNC_SETCURSOR = 4'd1;
    localparam logic [3:0] FUNC_DATA      = 4'd3;

    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [2:0] idx);
        logic [MAX_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/lcd_rr_picker.sv
// Combinational round-robin picker: first set request scanning ptr+1, ptr+2, ... modulo NUM_REQ.
module lcd_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // Scan from the requester after ptr; the first hit in scan order wins
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!valid && req[(int'(ptr) + i) % NUM_REQ]) begin
                valid = 1'b1;
                idx   = IDX_W'((int'(ptr) + i) % NUM_REQ);
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/lcd_req_arbiter.sv
// Burst-locked round-robin arbiter in front of the LCD driver.
// Optional WAIT-state abort timer enabled by defining LCD_ARB_TIMEOUT_EN.
module lcd_req_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int SIZE_DATA   = 8,
    parameter int SIZE_FUNC   = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ-1:0]             i_last,
    input  logic [NUM_REQ*SIZE_FUNC-1:0]   i_func,
    input  logic [NUM_REQ*SIZE_DATA-1:0]   i_data,
    output logic [NUM_REQ-1:0]             o_gnt,
    output logic [NUM_REQ-1:0]             o_ack,
    output logic                           o_lcd_valid,
    output logic [SIZE_FUNC-1:0]           o_lcd_func,
    output logic [SIZE_DATA-1:0]           o_lcd_data,
    input  logic                           i_lcd_ready,
    input  logic                           i_lcd_done,
    output logic                           o_busy,
    output logic                           o_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("lcd_req_arbiter: unsupported parameter set");
    end

    arb_state_e             state_r;
    logic [IDX_W-1:0]       gidx_r;
    logic [IDX_W-1:0]       ptr_r;
    logic [SIZE_FUNC-1:0]   func_r;
    logic [SIZE_DATA-1:0]   data_r;
    logic                   last_r;
    logic [NUM_REQ-1:0]     gnt_r;
    logic [NUM_REQ-1:0]     ack_r;
    logic                   valid_r;
    logic                   busy_r;
    logic                   timeout_r;
    logic [IDX_W-1:0]       pick_idx_s;
    logic                   pick_valid_s;

`ifdef LCD_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]       cnt_r;
`endif

    lcd_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req   (i_req),
        .ptr   (ptr_r),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    // Arbiter FSM with all outputs registered; the next beat is sampled on the done edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= ST_IDLE;
            gidx_r    <= '0;
            ptr_r     <= IDX_W'(NUM_REQ - 1);
            func_r    <= SIZE_FUNC'(FUNC_INIT);
            data_r    <= '0;
            last_r    <= 1'b0;
            gnt_r     <= '0;
            ack_r     <= '0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
            cnt_r     <= '0;
`endif
        end else begin
            ack_r     <= '0;
            timeout_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        state_r <= ST_ISSUE;
                        gidx_r  <= pick_idx_s;
                        func_r  <= i_func[pick_idx_s*SIZE_FUNC +: SIZE_FUNC];
                        data_r  <= i_data[pick_idx_s*SIZE_DATA +: SIZE_DATA];
                        last_r  <= i_last[pick_idx_s];
                        gnt_r   <= NUM_REQ'(idx_to_onehot(3'(pick_idx_s)));
                        valid_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (i_lcd_ready) begin
                        state_r <= ST_WAIT;
                        valid_r <= 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
                        cnt_r   <= '0;
`endif
                    end else if (!i_req[gidx_r]) begin
                        // Requester withdrew before the driver took the beat
                        state_r <= ST_IDLE;
                        ptr_r   <= gidx_r;
                        gnt_r   <= '0;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    if (i_lcd_done) begin
                        ack_r <= gnt_r;
                        if (last_r) begin
                            state_r <= ST_IDLE;
                            ptr_r   <= gidx_r;
                            gnt_r   <= '0;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_ISSUE;
                            func_r  <= i_func[gidx_r*SIZE_FUNC +: SIZE_FUNC];
                            data_r  <= i_data[gidx_r*SIZE_DATA +: SIZE_DATA];
                            last_r  <= i_last[gidx_r];
                            valid_r <= 1'b1;
                        end
`ifdef LCD_ARB_TIMEOUT_EN
                    end else if (cnt_r == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state_r   <= ST_IDLE;
                        ptr_r     <= gidx_r;
                        gnt_r     <= '0;
                        busy_r    <= 1'b0;
                        timeout_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
`else
                    end else begin
                        state_r <= ST_WAIT;
`endif
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= '0;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_gnt       = gnt_r;
    assign o_ack       = ack_r;
    assign o_lcd_valid = valid_r;
    assign o_lcd_func  = func_r;
    assign o_lcd_data  = data_r;
    assign o_busy      = busy_r;
`ifdef LCD_ARB_TIMEOUT_EN
    assign o_timeout   = timeout_r;
`else
    assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_req_arbiter.sv
// Directed table-driven bench for lcd_req_arbiter (2 requesters, 4-bit func, 8-bit data).
module tb_lcd_req_arbiter;
    import lcd_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0, last = '0;
    logic [7:0]  func = '0;
    logic [15:0] data = '0;
    logic        ready = 1'b0, done = 1'b0;
    logic [1:0]  gnt, ack;
    logic        valid, busy, tmo;
    logic [3:0]  lfunc;
    logic [7:0]  ldata;

    int checks = 0;
    int errors = 0;

    lcd_req_arbiter #(
        .NUM_REQ(2), .SIZE_DATA(8), .SIZE_FUNC(4), .TIMEOUT_CYC(16)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_last(last),
        .i_func(func), .i_data(data), .o_gnt(gnt), .o_ack(ack),
        .o_lcd_valid(valid), .o_lcd_func(lfunc), .o_lcd_data(ldata),
        .i_lcd_ready(ready), .i_lcd_done(done), .o_busy(busy), .o_timeout(tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [1:0]  req, last;
        logic [7:0]  func;
        logic [15:0] data;
        logic        ready, done;
        logic [1:0]  gnt, ack;
        logic        valid;
        logic [3:0]  efunc;
        logic [7:0]  edata;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, logic [1:0] rq, logic [1:0] ls, logic [7:0] fn,
                                logic [15:0] dt, logic rdy, logic dn, logic [1:0] eg,
                                logic [1:0] ea, logic ev, logic [3:0] ef, logic [7:0] ed,
                                logic eb);
        vec_t v;
        v.rst = r; v.req = rq; v.last = ls; v.func = fn; v.data = dt;
        v.ready = rdy; v.done = dn; v.gnt = eg; v.ack = ea; v.valid = ev;
        v.efunc = ef; v.edata = ed; v.busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, ".gnt"},   32'(gnt),   32'd0);
        chk({tag, ".ack"},   32'(ack),   32'd0);
        chk({tag, ".valid"}, 32'(valid), 32'd0);
        chk({tag, ".func"},  32'(lfunc), 32'd0);
        chk({tag, ".data"},  32'(ldata), 32'd0);
        chk({tag, ".busy"},  32'(busy),  32'd0);
        chk({tag, ".tmo"},   32'(tmo),   32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; last = '0; func = '0; data = '0; ready = 1'b0; done = 1'b0;
        #1;
        chk_idle_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // test 1: single beat, done 3 cycles after accept
        vecs.push_back(mk(1, 2'b01, 2'b01, 8'h01, 16'h0000, 1, 0, 2'b01, 2'b00, 1, FUNC_SETCURSOR, 8'h00, 1));
        vecs.push_back(mk(0, 2'b01, 2'b01, 8'h01, 16'h0000, 1, 0, 2'b01, 2'b00, 0, 4'h1, 8'h00, 1));
        vecs.push_back(mk(0, 2'b01, 2'b01, 8'h01, 16'h0000, 1, 0, 2'b01, 2'b00, 0, 4'h1, 8'h00, 1));
        vecs.push_back(mk(0, 2'b01, 2'b01, 8'h01, 16'h0000, 1, 0, 2'b01, 2'b00, 0, 4'h1, 8'h00, 1));
        vecs.push_back(mk(0, 2'b01, 2'b01, 8'h01, 16'h0000, 1, 1, 2'b00, 2'b01, 0, 4'h1, 8'h00, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 8'h01, 16'h0000, 1, 0, 2'b00, 2'b00, 0, 4'h1, 8'h00, 0));
        // test 2: both requesting, single-beat bursts alternate 0,1,0,1
        for (int b = 0; b < 4; b++) begin
            logic [1:0] g;
            logic [3:0] f;
            logic [7:0] d;
            g = (b % 2 == 0) ? 2'b01 : 2'b10;
            f = (b % 2 == 0) ? FUNC_SETCURSOR : FUNC_DATA;
            d = (b % 2 == 0) ? 8'h11 : 8'h22;
            vecs.push_back(mk(b == 0, 2'b11, 2'b11, 8'h31, 16'h2211, 1, 0, g, 2'b00, 1, f, d, 1));
            vecs.push_back(mk(0, 2'b11, 2'b11, 8'h31, 16'h2211, 1, 1, g, 2'b00, 0, f, d, 1));
            vecs.push_back(mk(0, 2'b11, 2'b11, 8'h31, 16'h2211, 1, 1, 2'b00, g, 0, f, d, 0));
        end
        // test 3: req0 two-beat burst locked while req1 waits
        vecs.push_back(mk(1, 2'b11, 2'b10, 8'h31, 16'h7700, 0, 0, 2'b01, 2'b00, 1, 4'h1, 8'h00, 1));
        vecs.push_back(mk(0, 2'b11, 2'b10, 8'h31, 16'h7700, 1, 0, 2'b01, 2'b00, 0, 4'h1, 8'h00, 1));
        vecs.push_back(mk(0, 2'b11, 2'b11, 8'h33, 16'h775A, 0, 1, 2'b01, 2'b01, 1, 4'h3, 8'h5A, 1));
        vecs.push_back(mk(0, 2'b11, 2'b11, 8'h33, 16'h775A, 1, 0, 2'b01, 2'b00, 0, 4'h3, 8'h5A, 1));
        vecs.push_back(mk(0, 2'b11, 2'b11, 8'h33, 16'h775A, 1, 1, 2'b00, 2'b01, 0, 4'h3, 8'h5A, 0));
        vecs.push_back(mk(0, 2'b11, 2'b11, 8'h33, 16'h775A, 0, 0, 2'b10, 2'b00, 1, 4'h3, 8'h77, 1));
        vecs.push_back(mk(0, 2'b11, 2'b11, 8'h33, 16'h775A, 1, 0, 2'b10, 2'b00, 0, 4'h3, 8'h77, 1));
        vecs.push_back(mk(0, 2'b11, 2'b11, 8'h33, 16'h775A, 1, 1, 2'b00, 2'b10, 0, 4'h3, 8'h77, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 8'h33, 16'h775A, 0, 0, 2'b00, 2'b00, 0, 4'h3, 8'h77, 0));
        // test 4: ready low 5 cycles, payload stable, then requester withdraws
        vecs.push_back(mk(0, 2'b01, 2'b01, 8'h01, 16'h003C, 0, 0, 2'b01, 2'b00, 1, 4'h1, 8'h3C, 1));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 2'b01, 2'b01, 8'h0F, 16'h00FF, 0, 1, 2'b01, 2'b00, 1, 4'h1, 8'h3C, 1));
        vecs.push_back(mk(0, 2'b00, 2'b00, 8'h0F, 16'h00FF, 0, 0, 2'b00, 2'b00, 0, 4'h1, 8'h3C, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 8'h0F, 16'h00FF, 0, 0, 2'b00, 2'b00, 0, 4'h1, 8'h3C, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            if (vecs[i].rst) do_reset();
            req = vecs[i].req; last = vecs[i].last; func = vecs[i].func;
            data = vecs[i].data; ready = vecs[i].ready; done = vecs[i].done;
            tick();
            tag = $sformatf("vec%0d", i);
            chk({tag, ".gnt"},   32'(gnt),   32'(vecs[i].gnt));
            chk({tag, ".ack"},   32'(ack),   32'(vecs[i].ack));
            chk({tag, ".valid"}, 32'(valid), 32'(vecs[i].valid));
            chk({tag, ".func"},  32'(lfunc), 32'(vecs[i].efunc));
            chk({tag, ".data"},  32'(ldata), 32'(vecs[i].edata));
            chk({tag, ".busy"},  32'(busy),  32'(vecs[i].busy));
            chk({tag, ".tmo"},   32'(tmo),   32'd0);
        end

        // test 5: asynchronous reset in WAIT clears everything, pointer restarts
        do_reset();
        req = 2'b01; last = 2'b01; func = 8'h01; data = 16'h0042; ready = 1'b1;
        tick();
        tick();
        chk("rstwait.busy", 32'(busy), 32'd1);
        chk("rstwait.valid", 32'(valid), 32'd0);
        #2;
        rst_n = 1'b0;
        done = 1'b1;
        #1;
        chk_idle_zero("rstwait.async");
        tick();
        tick();
        rst_n = 1'b1;
        req = 2'b10; last = 2'b10; ready = 1'b0; done = 1'b0;
        tick();
        chk("rstwait.gnt_req1", 32'(gnt), 32'h2);
        chk("rstwait.noack", 32'(ack), 32'd0);
        do_reset();
        req = 2'b11; last = 2'b11;
        tick();
        chk("rstwait.gnt_req0", 32'(gnt), 32'h1);

`ifdef LCD_ARB_TIMEOUT_EN
        // test 6: done never arrives, abort 16 cycles after accept
        do_reset();
        req = 2'b01; last = 2'b11; func = 8'h31; data = 16'h2211; ready = 1'b1;
        tick();
        tick();
        req = 2'b11;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k < 16) begin
                chk($sformatf("tmo.wait%0d", k), 32'(tmo), 32'd0);
            end else begin
                chk("tmo.pulse", 32'(tmo), 32'd1);
                chk("tmo.noack", 32'(ack), 32'd0);
                chk("tmo.gnt_drop", 32'(gnt), 32'd0);
            end
        end
        tick();
        chk("tmo.single", 32'(tmo), 32'd0);
        chk("tmo.next_gnt", 32'(gnt), 32'h2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_req_arbiter.md
Name: lcd_req_arbiter

Overview:
- Round-robin arbiter sharing the single LCD command/data path between NUM_REQ requesters, e.g. the decoder result writer and the status/init sequencer.
- Each requester presents bursts of (func, data) beats, for example SETCURSOR then DATA.
- The grant is locked for the whole burst, so beats from different requesters never interleave on the LCD.
- Sits between the LCD-facing controllers and the LCD driver, using a valid/ready issue handshake plus a done completion pulse.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- SIZE_DATA, 8, LCD data width
- SIZE_FUNC, 4, LCD function-code width
- TIMEOUT_CYC, 1024, cycles allowed in WAIT before abort (used only with the optional feature)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req  in  NUM_REQ  per-requester request; held high for the whole burst
- i_last  in  NUM_REQ  marks the requester's current beat as the final beat of its burst
- i_func  in  NUM_REQ*SIZE_FUNC  packed function codes; requester k occupies bits [k*SIZE_FUNC +: SIZE_FUNC]
- i_data  in  NUM_REQ*SIZE_DATA  packed data, same packing as i_func
- o_gnt  out  NUM_REQ  one-hot grant
- o_ack  out  NUM_REQ  one-cycle pulse when the granted beat completes; requester advances to its next beat
- o_lcd_valid  out  1  beat offered to the LCD driver
- o_lcd_func  out  SIZE_FUNC  function code of the offered beat
- o_lcd_data  out  SIZE_DATA  data of the offered beat
- i_lcd_ready  in  1  driver accepts the beat when o_lcd_valid & i_lcd_ready
- i_lcd_done  in  1  driver finished the accepted beat
- o_busy  out  1  high in any state other than IDLE
- o_timeout  out  1  one-cycle abort pulse

Behaviour:
- Reset values: o_gnt=0, o_ack=0, o_lcd_valid=0, o_lcd_func=0, o_lcd_data=0, o_busy=0, o_timeout=0.
- Reset internals: state=IDLE, round-robin pointer ptr=NUM_REQ-1, so req0 wins first. Reset mid-burst drops everything, with no ack.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any i_req is high, pick the first set bit scanning ptr+1, ptr+2, … modulo NUM_REQ; store it as gidx.
  - Capture that requester's func, data and last into the payload registers; go to ISSUE.
  - Latency: a request sampled at edge 0 gives o_gnt and o_lcd_valid high in cycle 1.
- ISSUE:
  - o_lcd_valid=1; o_lcd_func/o_lcd_data come from the payload registers and are stable while valid is high.
  - On valid & i_lcd_ready, go to WAIT.
  - If i_req[gidx] has dropped and ready is low: abandon. Go to IDLE with no ack and ptr=gidx.
  - i_lcd_done is ignored in ISSUE.
- WAIT:
  - o_lcd_valid=0. Dropping i_req is ignored here.
  - On i_lcd_done: pulse o_ack[gidx] in the next cycle.
    - If the stored last=1: go to IDLE and set ptr=gidx.
    - If last=0: recapture payload from requester gidx and go to ISSUE. o_ack and the new o_lcd_valid rise in the same cycle.
    - The requester must present its next beat by the cycle after it sees o_ack.
- o_gnt = onehot(gidx) whenever state≠IDLE; o_busy = (state≠IDLE).
- Fairness: a requester holding i_req continuously is granted at most once per NUM_REQ bursts while others are requesting. A lone requester is re-granted immediately (IDLE for 1 cycle between bursts).
- Simultaneous new requests never preempt a locked burst.

Optional Feature:
- Macro: LCD_ARB_TIMEOUT_EN.
- With the macro:
  - A counter runs in WAIT and clears on entering WAIT.
  - If TIMEOUT_CYC cycles pass without i_lcd_done: pulse o_timeout for 1 cycle, send no ack, go to IDLE, set ptr=gidx.
- Without the macro: WAIT waits indefinitely, o_timeout is tied to 0, and no counter is synthesised.

Decomposition:
- Shared package lcd_pkg:
  - FUNC_INIT=0, FUNC_SETCURSOR=1, FUNC_DATA=3.
  - Arbiter state enum.
  - Any helper functions for slicing the packed func/data vectors.
- One sub-module, lcd_rr_picker: combinational. Inputs are req vector and ptr; outputs are winner index and a valid flag. Reused by future shared-resource arbiters.

Test Plan:
- Reset, then req=01, last=1, func=1, data=0x00, ready=1, done 3 cycles after accept → o_gnt=01 at cycle 1, one o_lcd_valid cycle, o_ack=01 one cycle after done, back to IDLE.
- req=11 simultaneously, single-beat bursts, repeated 4 times → grant order 0,1,0,1; o_gnt always one-hot.
- Req0 two-beat burst (SETCURSOR 0x00, then DATA 0x5A, last=1) while req1 is high → driver sees func 1/0x00 then 3/0x5A with no req1 beat between; req1 granted next.
- ready held low 5 cycles in ISSUE → func/data stable for all 5 cycles. Then drop i_req[gidx] with ready still low → return to IDLE, no ack.
- Assert i_rst_n low during WAIT → all outputs 0 immediately; after release, req=10 is granted to req0 only if req0 is requesting; otherwise req1.
- With LCD_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, done never asserted → o_timeout pulses 16 cycles after accept, no ack, next requester granted.
